cas_key_loader: RTL and testbench

CAS_KEY_LOADER -- requirements
Module: cas_key_loader

---
 rtl/cas_key_loader_if.sv | 35 +++
 rtl/cas_key_loader.sv | 131 +++++++++++++
 tb/tb_cas_key_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cas_key_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : cas_key_loader_if
// Description : Control and key bus between a key source and cas_key_loader.
//               master : key source (drives load/clear/serial bits,
//                        observes key_word and status)
//               slave  : cas_key_loader
//               Signals: load_start, key_clear, key_bit_in, key_bit_valid
//                        (to loader); key_word[KEY_WIDTH], key_ready, busy,
//                        err (from loader).
// Revision    : 1.0 - initial release
// ============================================================================
interface cas_key_loader_if #(
   parameter int KEY_WIDTH = 64
);
   logic                 load_start;
   logic                 key_clear;
   logic                 key_bit_in;
   logic                 key_bit_valid;
   logic [KEY_WIDTH-1:0] key_word;
   logic                 key_ready;
   logic                 busy;
   logic                 err;

   modport master (
      output load_start, key_clear, key_bit_in, key_bit_valid,
      input  key_word, key_ready, busy, err
   );

   modport slave (
      input  load_start, key_clear, key_bit_in, key_bit_valid,
      output key_word, key_ready, busy, err
   );
endinterface
`default_nettype wire

// File: rtl/cas_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : cas_key_loader
// Description : Serial key loader for a CAS-locked core. Key bits arrive
//               LSB first into a shadow register; only a complete, checked
//               key is ever presented on key_word (all zeros otherwise).
//               Ports : clk, rst (synchronous, active-high)
//                       kif (cas_key_loader_if.slave):
//                         load_start, key_clear, key_bit_in, key_bit_valid in
//                         key_word[KEY_WIDTH], key_ready, busy, err out
//               Option: define CAS_KEY_PARITY_EN to accept one extra even
//                       parity bit after the key and reject bad parity.
// Revision    : 1.0 - initial release
// ============================================================================
module cas_key_loader #(
   parameter int KEY_WIDTH      = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic         clk,
   input  wire logic         rst,
   cas_key_loader_if.slave   kif
);

`ifdef CAS_KEY_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int             SHADOW_W = KEY_WIDTH + PAR_BITS;
   localparam logic [6:0]     LAST_IDX = 7'(SHADOW_W - 1);
   localparam logic [8:0]     TO_LIMIT = 9'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      CHECK = 3'd2,
      ARMED = 3'd3,
      ERROR = 3'd4
   } state_t;

   state_t                state_q,    state_d;
   logic [6:0]            count_q,    count_d;
   logic [7:0]            timeout_q,  timeout_d;
   logic [SHADOW_W-1:0]   shadow_q,   shadow_d;
   logic [KEY_WIDTH-1:0]  key_word_q, key_word_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         timeout_q  <= '0;
         shadow_q   <= '0;
         key_word_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         timeout_q  <= timeout_d;
         shadow_q   <= shadow_d;
         key_word_q <= key_word_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      timeout_d  = timeout_q;
      shadow_d   = shadow_q;
      key_word_d = '0;

      case (state_q)
         SHIFT: begin
            if (kif.key_bit_valid) begin
               for (int i = 0; i < SHADOW_W; i++) begin
                  if (count_q == 7'(i)) begin
                     shadow_d[i] = kif.key_bit_in;
                  end
               end
               count_d   = count_q + 7'd1;
               timeout_d = '0;
               if (count_q == LAST_IDX) begin
                  state_d = CHECK;
               end
            end else begin
               timeout_d = timeout_q + 8'd1;
               if (({1'b0, timeout_q} + 9'd1) >= TO_LIMIT) begin
                  state_d = ERROR;
               end
            end
         end
         CHECK: begin
`ifdef CAS_KEY_PARITY_EN
            // Even parity: key bits plus parity bit must XOR to zero.
            state_d = (^shadow_q) ? ERROR : ARMED;
`else
            state_d = ARMED;
`endif
         end
         default: ;  // IDLE, ARMED, ERROR wait for load_start / key_clear
      endcase

      // load_start restarts loading from every state.
      if (kif.load_start) begin
         state_d   = SHIFT;
         count_d   = '0;
         timeout_d = '0;
         shadow_d  = '0;
      end

      // key_clear overrides a simultaneous load_start.
      if (kif.key_clear) begin
         state_d   = IDLE;
         count_d   = '0;
         timeout_d = '0;
         shadow_d  = '0;
      end

      // key_word is non-zero only while ARMED: captured from the shadow
      // register on entry, then held.
      if (state_d == ARMED) begin
         key_word_d = (state_q == ARMED) ? key_word_q
                                         : shadow_q[KEY_WIDTH-1:0];
      end
   end

   assign kif.key_word  = key_word_q;
   assign kif.key_ready = (state_q == ARMED);
   assign kif.busy      = (state_q == SHIFT) || (state_q == CHECK);
   assign kif.err       = (state_q == ERROR);

endmodule
`default_nettype wire

// File: tb/tb_cas_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cas_key_loader
// Description : Directed self-checking bench for cas_key_loader. Expected
//               key words are queued when a load is driven and compared
//               when key_ready is observed.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cas_key_loader;

   localparam int KW = 64;
`ifdef CAS_KEY_PARITY_EN
   localparam int NB = KW + 1;
`else
   localparam int NB = KW;
`endif
   localparam logic [63:0] KEY_A = 64'h35CF6489E43BF677;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;
   int   busy_cnt = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   cas_key_loader_if #(.KEY_WIDTH(KW)) kif ();

   cas_key_loader #(
      .KEY_WIDTH      (KW),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif.slave)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (kif.busy) busy_cnt++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [64:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         kif.key_bit_in    = bits[i];
         kif.key_bit_valid = 1'b1;
         step();
      end
      kif.key_bit_valid = 1'b0;
      kif.key_bit_in    = 1'b0;
   endtask

   task automatic pulse_load();
      kif.load_start = 1'b1;
      step();
      kif.load_start = 1'b0;
   endtask

   // Full load with correct parity (parity bit only sent when enabled).
   task automatic load_key(input logic [63:0] key);
      pulse_load();
      send_bits({^key, key}, NB);
   endtask

   // Called right after the final bit edge: CHECK lasts one cycle.
   task automatic wait_armed(input string tag);
      int n;
      logic [63:0] e;
      n = 0;
      check({tag, " check_not_ready"}, 64'(kif.key_ready), 64'd0);
      while (!kif.key_ready && !kif.err && n < 8) begin
         step();
         n++;
      end
      check({tag, " ready_latency"}, 64'(n), 64'd1);
      check({tag, " key_ready"}, 64'(kif.key_ready), 64'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, " key_word"}, kif.key_word, e);
      end else begin
         check({tag, " scoreboard_empty"}, 64'd1, 64'd0);
      end
   endtask

   initial begin
      logic [63:0] k2;
      kif.load_start    = 1'b0;
      kif.key_clear     = 1'b0;
      kif.key_bit_in    = 1'b0;
      kif.key_bit_valid = 1'b0;

      // Reset state
      rst = 1'b1;
      step(); step();
      check("rst key_word", kif.key_word, 64'd0);
      check("rst flags", {61'd0, kif.key_ready, kif.busy, kif.err}, 64'd0);
      rst = 1'b0;
      step();

      // Nominal load and busy duration
      busy_cnt = 0;
      exp_q.push_back(KEY_A);
      pulse_load();
      check("A busy_after_start", 64'(kif.busy), 64'd1);
      send_bits({^KEY_A, KEY_A}, NB);
      check("A word_zero_in_check", kif.key_word, 64'd0);
      wait_armed("A");
      check("A busy_cycles", 64'(busy_cnt), 64'(NB + 1));
      check("A busy_low", 64'(kif.busy), 64'd0);

      // Bits outside SHIFT ignored; key held while ARMED
      send_bits({1'b0, ~KEY_A}, 20);
      check("A hold word", kif.key_word, KEY_A);
      check("A hold ready", 64'(kif.key_ready), 64'd1);

`ifdef CAS_KEY_PARITY_EN
      // Bad parity -> ERROR, zero key
      pulse_load();
      send_bits({~^KEY_A, KEY_A}, NB);
      step();
      check("par_bad err", 64'(kif.err), 64'd1);
      check("par_bad word", kif.key_word, 64'd0);
`endif

      // Timeout after 10 bits
      pulse_load();
      send_bits({1'b0, KEY_A}, 10);
      for (int i = 0; i < 254; i++) step();
      check("to 254 err", 64'(kif.err), 64'd0);
      check("to 254 busy", 64'(kif.busy), 64'd1);
      step();
      check("to 255 err", 64'(kif.err), 64'd1);
      check("to 255 word", kif.key_word, 64'd0);
      send_bits({1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 5);
      check("err hold", 64'(kif.err), 64'd1);
      check("err hold busy", 64'(kif.busy), 64'd0);
      k2 = {$urandom(), $urandom()};
      exp_q.push_back(k2);
      load_key(k2);
      wait_armed("after_to");

      // Restart mid-load with all ones
      pulse_load();
      send_bits({1'b0, 64'h0}, 40);
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      load_key(64'hFFFF_FFFF_FFFF_FFFF);
      wait_armed("restart ones");

      // Restart mid-load after ones with a mixed key
      pulse_load();
      send_bits({1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 40);
      k2 = 64'h0123_4567_89AB_CDEF;
      exp_q.push_back(k2);
      load_key(k2);
      wait_armed("restart mixed");

      // key_clear wins over load_start in ARMED
      kif.key_clear  = 1'b1;
      kif.load_start = 1'b1;
      step();
      kif.key_clear  = 1'b0;
      kif.load_start = 1'b0;
      check("clr word", kif.key_word, 64'd0);
      check("clr flags", {61'd0, kif.key_ready, kif.busy, kif.err}, 64'd0);
      send_bits({1'b1, KEY_A}, 64);
      check("clr idle_ignores", {61'd0, kif.key_ready, kif.busy, kif.err}, 64'd0);

      // key_clear mid-shift
      pulse_load();
      send_bits({1'b0, KEY_A}, 20);
      kif.key_clear = 1'b1;
      step();
      kif.key_clear = 1'b0;
      check("clr_mid busy", 64'(kif.busy), 64'd0);

      // Reset mid-load after 30 bits
      pulse_load();
      send_bits({1'b0, KEY_A}, 30);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid word", kif.key_word, 64'd0);
      check("rst_mid flags", {61'd0, kif.key_ready, kif.busy, kif.err}, 64'd0);
      send_bits({1'b1, KEY_A}, 70);
      step(); step();
      check("rst_mid after_bits word", kif.key_word, 64'd0);
      check("rst_mid after_bits flags",
            {61'd0, kif.key_ready, kif.busy, kif.err}, 64'd0);

      check("scoreboard drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
